// File: rtl/uart_pkg.sv
// uart_pkg: UART state encoding, parity modes and a bit-vote helper,
// shared by the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: show-ahead receive FIFO; the head entry is visible
// without a read, and the last popped word is held while empty.
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_cnt;
  logic [WIDTH-1:0] r_hold;
  logic             w_wr;
  logic             w_rd;

  assign full    = (r_cnt == FULL_CNT);
  assign empty   = (r_cnt == '0);
  assign w_rd    = rd_en & ~empty;
  // a full FIFO still accepts a write when a pop frees a slot this cycle
  assign w_wr    = wr_en & (~full | w_rd);
  assign rd_data = empty ? r_hold : r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_cnt  <= '0;
      r_hold <= '0;
    end else begin
      if (w_wr) r_wr <= r_wr + AW'(1);
      if (w_rd) begin
        r_rd   <= r_rd + AW'(1);
        r_hold <= r_mem[r_rd];
      end
      unique case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: oversampling UART deframer feeding a receive FIFO.
// Define UART_RX_MAJORITY_EN for 2-of-3 voting around each bit midpoint.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk_50m,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic                 clken,
  input  logic                 rd_en,
  input  logic                 err_clr,
  output logic [DATA_BITS-1:0] data,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 valid,
  output logic                 overrun
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam int FW = DATA_BITS + 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int MID = OVERSAMPLE / 2 + 1;
`else
  localparam int MID = OVERSAMPLE / 2;
`endif
  localparam logic [SW-1:0] C_MID  = SW'(MID);
  localparam logic [SW-1:0] C_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] C_BLST = BW'(DATA_BITS - 1);

  uart_state_e          r_state;
  uart_state_e          w_nxt;
  logic [1:0]           r_sync;
  logic [SW-1:0]        r_sample;
  logic [SW-1:0]        w_smp_nxt;
  logic [BW-1:0]        r_bitpos;
  logic [BW-1:0]        w_pos_nxt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_err;
  logic                 r_overrun;
  logic                 w_rx;
  logic                 w_bit;
  logic                 w_cap_d;
  logic                 w_cap_p;
  logic                 w_push;
  logic                 w_full;
  logic                 w_empty;
  logic [FW-1:0]        w_wdata;
  logic [FW-1:0]        w_rdata;

  assign w_rx = r_sync[1];

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] r_hist;

  // r_hist holds the two ticks before the decision tick
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n)     r_hist <= 2'b11;
    else if (clken) r_hist <= {r_hist[0], w_rx};
  end

  assign w_bit = maj3(r_hist[1], r_hist[0], w_rx);
`else
  assign w_bit = w_rx;
`endif

  always_comb begin
    w_nxt     = r_state;
    w_smp_nxt = r_sample;
    w_pos_nxt = r_bitpos;
    w_cap_d   = 1'b0;
    w_cap_p   = 1'b0;
    w_push    = 1'b0;
    if (clken) begin
      w_smp_nxt = r_sample + SW'(1);
      unique case (r_state)
        ST_IDLE: begin
          w_smp_nxt = '0;
          if (!w_rx) begin
            w_nxt     = ST_START;
            w_smp_nxt = SW'(1);
          end
        end
        ST_START: begin
          if (r_sample == C_MID && w_bit) begin
            w_nxt     = ST_IDLE;
            w_smp_nxt = '0;
          end else if (r_sample == C_LAST) begin
            w_nxt     = ST_DATA;
            w_smp_nxt = '0;
            w_pos_nxt = '0;
          end
        end
        ST_DATA: begin
          w_cap_d = (r_sample == C_MID);
          if (r_sample == C_LAST) begin
            w_smp_nxt = '0;
            if (r_bitpos == C_BLST)
              w_nxt = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            else
              w_pos_nxt = r_bitpos + BW'(1);
          end
        end
        ST_PARITY: begin
          w_cap_p = (r_sample == C_MID);
          if (r_sample == C_LAST) begin
            w_nxt     = ST_STOP;
            w_smp_nxt = '0;
          end
        end
        ST_STOP: begin
          // leave at the midpoint so the next start edge is caught early
          if (r_sample == C_MID) begin
            w_push    = 1'b1;
            w_nxt     = ST_IDLE;
            w_smp_nxt = '0;
          end
        end
        default: begin
          w_nxt     = ST_IDLE;
          w_smp_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      r_sync    <= 2'b11;
      r_state   <= ST_IDLE;
      r_sample  <= '0;
      r_bitpos  <= '0;
      r_shift   <= '0;
      r_par_err <= 1'b0;
    end else begin
      r_sync   <= {r_sync[0], rx};
      r_state  <= w_nxt;
      r_sample <= w_smp_nxt;
      r_bitpos <= w_pos_nxt;
      if (w_cap_d) r_shift[r_bitpos] <= w_bit;
      if (r_state == ST_IDLE)
        r_par_err <= 1'b0;
      else if (w_cap_p)
        r_par_err <= ((^r_shift) ^ w_bit) != (PARITY == PAR_ODD);
    end
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n)                     r_overrun <= 1'b0;
    else if (w_push && w_full && !rd_en) r_overrun <= 1'b1;
    else if (err_clr)               r_overrun <= 1'b0;
  end

  assign w_wdata = {r_shift, ~w_bit, r_par_err};

  uart_rx_fifo #(
    .WIDTH(FW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk_50m),
    .rst_n  (rst_n),
    .wr_en  (w_push),
    .wr_data(w_wdata),
    .rd_en  (rd_en),
    .rd_data(w_rdata),
    .full   (w_full),
    .empty  (w_empty)
  );

  assign data       = w_rdata[FW-1:2];
  assign frame_err  = w_rdata[1];
  assign parity_err = w_rdata[0];
  assign valid      = ~w_empty;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: scoreboard bench for an 8N1 and an 8E1 receiver
// sharing one stimulus line, clken tied high.
module tb_uart_receiver;
  import uart_pkg::*;

  localparam int OS = 16;

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic rst_n, line, sel_b, clken, rd_en, err_clr;
  logic [7:0] d_a, d_b;
  logic fe_a, pe_a, v_a, ov_a;
  logic fe_b, pe_b, v_b, ov_b;
  wire rx_a = sel_b ? 1'b1 : line;
  wire rx_b = sel_b ? line : 1'b1;
  wire rd_a = rd_en & ~sel_b;
  wire rd_b = rd_en & sel_b;
  wire [7:0] o_d = sel_b ? d_b : d_a;
  wire o_fe = sel_b ? fe_b : fe_a;
  wire o_pe = sel_b ? pe_b : pe_a;
  wire o_v  = sel_b ? v_b : v_a;
  wire o_ov = sel_b ? ov_b : ov_a;

  uart_receiver u_a (
    .clk_50m(clk), .rst_n(rst_n), .rx(rx_a), .clken(clken),
    .rd_en(rd_a), .err_clr(err_clr), .data(d_a),
    .frame_err(fe_a), .parity_err(pe_a), .valid(v_a),
    .overrun(ov_a)
  );

  uart_receiver #(.PARITY(PAR_EVEN)) u_b (
    .clk_50m(clk), .rst_n(rst_n), .rx(rx_b), .clken(clken),
    .rd_en(rd_b), .err_clr(err_clr), .data(d_b),
    .frame_err(fe_b), .parity_err(pe_b), .valid(v_b),
    .overrun(ov_b)
  );

  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic v, input bit glitch);
    line = v;
    if (glitch) begin
      tick(OS / 2);
      line = ~v;
      tick(1);
      line = v;
      tick(OS / 2 - 1);
    end else begin
      tick(OS);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit has_par,
                            input logic pbit, input logic stop,
                            input int gbit);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i], gbit == i);
    if (has_par) send_bit(pbit, 1'b0);
    send_bit(stop, 1'b0);
    line = 1'b1;
    tick(2 * OS);
  endtask

  task automatic drain(input int n);
    exp_t e;
    int k;
    for (int i = 0; i < n; i++) begin
      k = 0;
      while (!o_v && k < 1000) begin
        tick(1);
        k++;
      end
      chk("valid_wait", o_v, 1);
      if (!o_v) return;
      if (q.size() == 0) begin
        chk("sb_empty", 1, 0);
        return;
      end
      e = q.pop_front();
      chk("data", o_d, e.d);
      chk("frame_err", o_fe, e.fe);
      chk("parity_err", o_pe, e.pe);
      rd_en = 1'b1;
      tick(1);
      rd_en = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; line = 1'b1; sel_b = 1'b0;
    clken = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
    tick(3);
    chk("rst_valid", v_a, 0);
    chk("rst_data", d_a, 0);
    chk("rst_fe", fe_a, 0);
    chk("rst_pe", pe_a, 0);
    chk("rst_ov", ov_a, 0);
    rst_n = 1'b1;
    tick(2);

    q.push_back('{8'hA5, 1'b0, 1'b0});
    send_frame(8'hA5, 0, 0, 1, -1);
    drain(1);
    chk("a5_empty", v_a, 0);

    q.push_back('{8'h55, 1'b1, 1'b0});
    send_frame(8'h55, 0, 0, 0, -1);
    q.push_back('{8'h0F, 1'b0, 1'b0});
    send_frame(8'h0F, 0, 0, 1, -1);
    drain(2);

    line = 1'b0;
    tick(4);
    line = 1'b1;
    tick(3 * OS);
    chk("false_start", v_a, 0);
    q.push_back('{8'h3E, 1'b0, 1'b0});
    send_frame(8'h3E, 0, 0, 1, -1);
    drain(1);

`ifdef UART_RX_MAJORITY_EN
    q.push_back('{8'hFF, 1'b0, 1'b0});
    send_frame(8'hFF, 0, 0, 1, 3);
    drain(1);
`endif

    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) q.push_back('{8'(i), 1'b0, 1'b0});
      send_frame(8'(i), 0, 0, 1, -1);
    end
    chk("ov_set", ov_a, 1);
    drain(4);
    chk("ov_empty", v_a, 0);
    chk("ov_sticky", ov_a, 1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("ov_clr", ov_a, 0);

    sel_b = 1'b1;
    q.push_back('{8'h3C, 1'b0, 1'b1});
    send_frame(8'h3C, 1, 1, 1, -1);
    q.push_back('{8'h3C, 1'b0, 1'b0});
    send_frame(8'h3C, 1, 0, 1, -1);
    drain(2);
    chk("par_ov", o_ov, 0);
    sel_b = 1'b0;

    send_frame(8'h77, 0, 0, 1, -1);
    chk("pre_rst_valid", v_a, 1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    line = 1'b0;
    tick(OS / 2);
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", v_a, 0);
    chk("mrst_data", d_a, 0);
    chk("mrst_fe", fe_a, 0);
    chk("mrst_pe", pe_a, 0);
    chk("mrst_ov", ov_a, 0);
    line = 1'b1;
    tick(OS);
    rst_n = 1'b1;
    tick(OS);
    q.push_back('{8'hC3, 1'b0, 1'b0});
    send_frame(8'hC3, 0, 0, 1, -1);
    drain(1);
    chk("sb_left", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
